// File: rtl/banked_dual_sram_if.sv
// banked_dual_sram_if: access bus of the banked dual-port SRAM.
// Per-bank strobes/addresses/data in, registered read data/flags out.
interface banked_dual_sram_if #(
  parameter int Data_Width = 8,
  parameter int Para_Deg   = 2,
  parameter int Addr_Width = 4,
  parameter int Nums_Bank  = 3
);
  logic [Nums_Bank-1:0]                     Mem_Clear;
  logic [Nums_Bank-1:0]                     Chip_Select;
  logic [Nums_Bank-1:0]                     En_Write;
  logic [Nums_Bank-1:0]                     En_Read;
  logic [Nums_Bank*Para_Deg-1:0]            Write_Mask;
  logic [Nums_Bank*Addr_Width-1:0]          Write_Addr;
  logic [Nums_Bank*Addr_Width-1:0]          Read_Addr;
  logic [Nums_Bank*Para_Deg*Data_Width-1:0] Write_Data;
  logic [Nums_Bank*Para_Deg*Data_Width-1:0] Read_Data;
  logic [Nums_Bank-1:0]                     Read_Valid;
  logic [Nums_Bank-1:0]                     Addr_Err;
  logic                                     Busy;

  modport master (
    output Mem_Clear, Chip_Select, En_Write, En_Read,
    output Write_Mask, Write_Addr, Read_Addr, Write_Data,
    input  Read_Data, Read_Valid, Addr_Err, Busy
  );

  modport slave (
    input  Mem_Clear, Chip_Select, En_Write, En_Read,
    input  Write_Mask, Write_Addr, Read_Addr, Write_Data,
    output Read_Data, Read_Valid, Addr_Err, Busy
  );
endinterface

// File: rtl/banked_dual_sram.sv
// banked_dual_sram: Nums_Bank simple dual-port SRAM banks, lane write
// mask, registered read with valid, write-first bypass, swept clear.
// Ports: clk, Reset (sync, active high), bus (banked_dual_sram_if.slave):
//  Mem_Clear/Chip_Select/En_Write/En_Read per bank, Write_Mask per lane,
//  Write_Addr/Read_Addr/Write_Data in; Read_Data/Read_Valid/Addr_Err/Busy out.
module banked_dual_sram #(
  parameter int Data_Width = 8,
  parameter int Para_Deg   = 2,
  parameter int Addr_Width = 4,
  parameter int Ram_Depth  = 16,
  parameter int Nums_Bank  = 3
) (
  input  logic clk,
  input  logic Reset,
  banked_dual_sram_if.slave bus
);
  localparam int W = Para_Deg * Data_Width;
  localparam logic [Addr_Width:0] DEPTH =
    (Addr_Width+1)'(Ram_Depth);
  localparam logic [Addr_Width-1:0] LAST =
    Addr_Width'(Ram_Depth - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [Addr_Width-1:0] r_clr_addr;
  logic [Addr_Width-1:0] w_clr_addr_nxt;
  logic [Nums_Bank-1:0]  r_clr_mask;
  logic [Nums_Bank-1:0]  w_clr_mask_nxt;
  logic                  w_busy;
  logic                  w_clr_we;
  logic                  w_acc_ok;

  logic [W-1:0]           r_mem [Nums_Bank][Ram_Depth];
  logic [Nums_Bank*W-1:0] r_rdata;
  logic [Nums_Bank-1:0]   r_rvalid;
  logic [Nums_Bank-1:0]   r_aerr;

  logic [Addr_Width-1:0] w_waddr [Nums_Bank];
  logic [Addr_Width-1:0] w_raddr [Nums_Bank];
  logic [W-1:0]          w_rword [Nums_Bank];
  logic [Nums_Bank-1:0]  w_we;
  logic [Nums_Bank-1:0]  w_re;
  logic [Nums_Bank-1:0]  w_woor;
  logic [Nums_Bank-1:0]  w_roor;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_clr_mask <= '1;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_clr_mask <= w_clr_mask_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_mask_nxt = r_clr_mask;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.Mem_Clear) begin
          w_state_nxt    = S_CLEAR;
          w_clr_mask_nxt = bus.Mem_Clear;
          w_clr_addr_nxt = '0;
        end
      end
      S_CLEAR: begin
        w_clr_addr_nxt = r_clr_addr + 1'b1;
        if (r_clr_addr == LAST) begin
          w_state_nxt    = S_IDLE;
          w_clr_addr_nxt = '0;
        end
      end
    endcase
  end

  // The cycle that launches a clear accepts no user access.
  always_comb begin
    w_busy   = (r_state == S_CLEAR);
    w_clr_we = w_busy;
    w_acc_ok = (r_state == S_IDLE) & ~(|bus.Mem_Clear);
  end

  always_comb begin
    for (int b = 0; b < Nums_Bank; b++) begin
      w_waddr[b] = bus.Write_Addr[b*Addr_Width +: Addr_Width];
      w_raddr[b] = bus.Read_Addr[b*Addr_Width +: Addr_Width];
      w_woor[b]  = {1'b0, w_waddr[b]} >= DEPTH;
      w_roor[b]  = {1'b0, w_raddr[b]} >= DEPTH;
      w_we[b]    = w_acc_ok & bus.Chip_Select[b] & bus.En_Write[b];
      w_re[b]    = w_acc_ok & bus.Chip_Select[b] & bus.En_Read[b];
      w_rword[b] = '0;
      if (!w_roor[b]) begin
        w_rword[b] = r_mem[b][w_raddr[b]];
        // Write-first: lanes written this cycle bypass to the read.
        for (int l = 0; l < Para_Deg; l++) begin
          if (w_we[b] && !w_woor[b] &&
              (w_waddr[b] == w_raddr[b]) &&
              bus.Write_Mask[b*Para_Deg+l]) begin
            w_rword[b][l*Data_Width +: Data_Width] =
              bus.Write_Data[b*W + l*Data_Width +: Data_Width];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_rdata  <= '0;
      r_rvalid <= '0;
      r_aerr   <= '0;
    end else begin
      for (int b = 0; b < Nums_Bank; b++) begin
        if (w_clr_we && r_clr_mask[b]) begin
          r_mem[b][r_clr_addr] <= '0;
        end else if (w_we[b] && !w_woor[b]) begin
          for (int l = 0; l < Para_Deg; l++) begin
            if (bus.Write_Mask[b*Para_Deg+l]) begin
              r_mem[b][w_waddr[b]][l*Data_Width +: Data_Width] <=
                bus.Write_Data[b*W + l*Data_Width +: Data_Width];
            end
          end
        end
        if (w_re[b]) begin
          r_rdata[b*W +: W] <= w_rword[b];
        end
        r_rvalid[b] <= w_re[b];
        r_aerr[b]   <= (w_we[b] & w_woor[b]) |
                       (w_re[b] & w_roor[b]);
      end
    end
  end

  assign bus.Read_Data  = r_rdata;
  assign bus.Read_Valid = r_rvalid;
  assign bus.Addr_Err   = r_aerr;
  assign bus.Busy       = w_busy;

endmodule

// File: tb/tb_banked_dual_sram.sv
// tb_banked_dual_sram: directed checks of banked_dual_sram.
// Instance a: default geometry; instance b: 16-bit lanes, 12 words.
module tb_banked_dual_sram;
  logic clk = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  banked_dual_sram_if #(
    .Data_Width(8), .Para_Deg(2), .Addr_Width(4), .Nums_Bank(3)
  ) ifa ();
  banked_dual_sram_if #(
    .Data_Width(16), .Para_Deg(2), .Addr_Width(4), .Nums_Bank(3)
  ) ifb ();

  banked_dual_sram #(
    .Data_Width(8), .Para_Deg(2), .Addr_Width(4),
    .Ram_Depth(16), .Nums_Bank(3)
  ) u_dut_a (
    .clk(clk), .Reset(Reset), .bus(ifa.slave)
  );

  banked_dual_sram #(
    .Data_Width(16), .Para_Deg(2), .Addr_Width(4),
    .Ram_Depth(12), .Nums_Bank(3)
  ) u_dut_b (
    .clk(clk), .Reset(Reset), .bus(ifb.slave)
  );

  task automatic check(input string tag,
                       input logic [95:0] obs,
                       input logic [95:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.Mem_Clear   = '0;
    ifa.Chip_Select = '0;
    ifa.En_Write    = '0;
    ifa.En_Read     = '0;
    ifa.Write_Mask  = '0;
    ifa.Write_Addr  = '0;
    ifa.Read_Addr   = '0;
    ifa.Write_Data  = '0;
  endtask

  task automatic idle_b();
    ifb.Mem_Clear   = '0;
    ifb.Chip_Select = '0;
    ifb.En_Write    = '0;
    ifb.En_Read     = '0;
    ifb.Write_Mask  = '0;
    ifb.Write_Addr  = '0;
    ifb.Read_Addr   = '0;
    ifb.Write_Data  = '0;
  endtask

  task automatic busy_len_a(output int n);
    n = 0;
    while (ifa.Busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [15:0] fill_w(input int b, input int a);
    logic [3:0] hb;
    logic [3:0] ha;
    logic [7:0] lo;
    hb = 4'(b + 1);
    ha = 4'(a);
    lo = 8'hF0 ^ 8'(a);
    return {hb, ha, lo};
  endfunction

  task automatic read_all_a(input string tag, input logic [2:0] zb);
    logic [47:0] exp;
    for (int a = 0; a < 16; a++) begin
      ifa.Chip_Select = '1;
      ifa.En_Read     = '1;
      ifa.Read_Addr   = {3{4'(a)}};
      tick();
      exp = {fill_w(2, a), fill_w(1, a), fill_w(0, a)};
      for (int b = 0; b < 3; b++)
        if (zb[b]) exp[b*16 +: 16] = 16'h0;
      check(tag, ifa.Read_Data, exp);
    end
    idle_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int nb;
    int n;
    logic anyv;

    Reset = 1'b1;
    idle_a();
    idle_b();
    tick();
    tick();
    check("rst_rdata_a", ifa.Read_Data, 48'h0);
    check("rst_valid_a", ifa.Read_Valid, 3'b000);
    check("rst_aerr_a", ifa.Addr_Err, 3'b000);
    check("rst_busy_a", ifa.Busy, 1'b1);
    check("rst_busy_b", ifb.Busy, 1'b1);

    // 1: release, sweep lengths, everything reads zero
    Reset = 1'b0;
    na = 0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.Busy) na++;
      if (ifb.Busy) nb++;
      if (!ifa.Busy && !ifb.Busy) break;
      tick();
    end
    check("busy_len_a", na, 16);
    check("busy_len_b", nb, 12);
    for (int a = 0; a < 16; a++) begin
      ifa.Chip_Select = '1;
      ifa.En_Read     = '1;
      ifa.Read_Addr   = {3{4'(a)}};
      tick();
      check("t1_valid", ifa.Read_Valid, 3'b111);
      check("t1_zero", ifa.Read_Data, 48'h0);
    end
    idle_a();
    tick();
    check("t1_valid_drop", ifa.Read_Valid, 3'b000);

    // 2: bank0 write then read
    ifa.Chip_Select = 3'b001;
    ifa.En_Write    = 3'b001;
    ifa.Write_Addr  = 12'h003;
    ifa.Write_Data  = 48'h0705;
    ifa.Write_Mask  = 6'b000011;
    tick();
    idle_a();
    ifa.Chip_Select = 3'b001;
    ifa.En_Read     = 3'b001;
    ifa.Read_Addr   = 12'h003;
    tick();
    check("t2_rdata0", ifa.Read_Data[15:0], 16'h0705);
    check("t2_others", ifa.Read_Data[47:16], 32'h0);
    check("t2_valid", ifa.Read_Valid, 3'b001);
    idle_a();

    // 3a: bank1 collision, upper lane masked in
    ifa.Chip_Select = 3'b010;
    ifa.En_Write    = 3'b010;
    ifa.Write_Addr  = 12'h050;
    ifa.Write_Data  = 48'h0000_1122_0000;
    ifa.Write_Mask  = 6'b001100;
    tick();
    ifa.En_Read     = 3'b010;
    ifa.Read_Addr   = 12'h050;
    ifa.Write_Data  = 48'h0000_3344_0000;
    ifa.Write_Mask  = 6'b001000;
    tick();
    check("t3a_bypass", ifa.Read_Data[31:16], 16'h3322);
    idle_a();
    ifa.Chip_Select = 3'b010;
    ifa.En_Read     = 3'b010;
    ifa.Read_Addr   = 12'h050;
    tick();
    check("t3a_stored", ifa.Read_Data[31:16], 16'h3322);
    idle_a();

    // 3b: 16-bit bank2 collision, lane0 masked in
    ifb.Chip_Select = 3'b100;
    ifb.En_Write    = 3'b100;
    ifb.Write_Addr  = 12'hA00;
    ifb.Write_Data  = {32'h0004_0001, 64'h0};
    ifb.Write_Mask  = 6'b110000;
    tick();
    ifb.En_Read     = 3'b100;
    ifb.Read_Addr   = 12'hA00;
    ifb.Write_Data  = {32'hBEEF_0009, 64'h0};
    ifb.Write_Mask  = 6'b010000;
    tick();
    check("t3b_bypass", ifb.Read_Data[95:64], 32'h0004_0009);
    check("t3b_valid", ifb.Read_Valid, 3'b100);
    idle_b();

    // 5: out-of-range on 12-word instance
    ifb.Chip_Select = 3'b001;
    ifb.En_Write    = 3'b001;
    ifb.Write_Addr  = 12'h001;
    ifb.Write_Data  = 96'h1234_5678;
    ifb.Write_Mask  = 6'b000011;
    tick();
    check("t5_inrange_err", ifb.Addr_Err, 3'b000);
    ifb.Write_Addr  = 12'h00D;
    ifb.Write_Data  = '1;
    tick();
    check("t5_wr_err", ifb.Addr_Err, 3'b001);
    idle_b();
    tick();
    check("t5_err_pulse", ifb.Addr_Err, 3'b000);
    ifb.Chip_Select = 3'b001;
    ifb.En_Read     = 3'b001;
    ifb.Read_Addr   = 12'h001;
    tick();
    check("t5_no_alias", ifb.Read_Data[31:0], 32'h1234_5678);
    ifb.Read_Addr   = 12'h00E;
    tick();
    check("t5_rd_zero", ifb.Read_Data[31:0], 32'h0);
    check("t5_rd_valid", ifb.Read_Valid, 3'b001);
    check("t5_rd_err", ifb.Addr_Err, 3'b001);
    idle_b();

    // 4: fill, clear bank1 only, strobes ignored while sweeping
    for (int a = 0; a < 16; a++) begin
      ifa.Chip_Select = '1;
      ifa.En_Write    = '1;
      ifa.Write_Mask  = '1;
      ifa.Write_Addr  = {3{4'(a)}};
      ifa.Write_Data  = {fill_w(2, a), fill_w(1, a), fill_w(0, a)};
      tick();
    end
    idle_a();
    ifa.Mem_Clear   = 3'b010;
    ifa.Chip_Select = '1;
    ifa.En_Write    = '1;
    ifa.En_Read     = '1;
    ifa.Write_Mask  = '1;
    ifa.Write_Data  = '1;
    tick();
    ifa.Mem_Clear = '0;
    n = 0;
    anyv = 1'b0;
    while (ifa.Busy && n < 40) begin
      n++;
      anyv |= |ifa.Read_Valid;
      ifa.Write_Addr = {3{4'(n)}};
      tick();
    end
    idle_a();
    check("t4_busy_len", n, 16);
    check("t4_no_valid", anyv, 1'b0);
    read_all_a("t4_data", 3'b010);

    // 6: reset mid-sweep restarts a full sweep of every bank
    ifa.Mem_Clear = 3'b001;
    tick();
    ifa.Mem_Clear = '0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_busy_mid", ifa.Busy, 1'b1);
    Reset = 1'b1;
    tick();
    check("t6_busy_rst", ifa.Busy, 1'b1);
    check("t6_rdata_rst", ifa.Read_Data, 48'h0);
    Reset = 1'b0;
    busy_len_a(n);
    check("t6_busy_len", n, 16);
    read_all_a("t6_data", 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
